// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: fetch-side bus bundle for inst_fetch_ctrl.
//   imem_addr/imem_data   : instruction memory port (combinational read)
//   redirect_valid/_pc    : branch/jump redirect request
//   halt                  : stop issuing fetches
//   dec_valid/_instr/_pc  : queue head presented to decode
//   dec_ready             : decode accepts head this cycle
//   busy                  : controller running or queue non-empty
// modport master : the fetch controller
// modport slave  : memory + pipeline environment
interface inst_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        busy;

  modport master (
    output imem_addr, dec_valid, dec_instr, dec_pc, busy,
    input  imem_data, redirect_valid, redirect_pc, halt, dec_ready
  );

  modport slave (
    input  imem_addr, dec_valid, dec_instr, dec_pc, busy,
    output imem_data, redirect_valid, redirect_pc, halt, dec_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch controller with a QDEPTH-entry
// prefetch queue (no bypass) between instruction memory and decode.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : inst_fetch_ctrl_if.master (imem, redirect, halt, decode, busy)
//   fetch_count : push counter, present only with FETCH_PERF_CNT_EN
// Params: RESET_PC (first fetch address), QDEPTH (power of two, 2..8).
// Optional feature macro: FETCH_PERF_CNT_EN.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input logic              clk,
  input logic              rst,
  inst_fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      fetch_count
`endif
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_e                   state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t [QDEPTH-1:0]      q_mem_q, q_mem_d;
  logic                     pop, push;

  // redirect targets are word aligned; low bits intentionally dropped
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.redirect_pc[1:0]};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    q_mem_d  = q_mem_q;

    pop  = (count_q != '0) && bus.dec_ready;
    // a pop frees a slot this cycle, so a full queue can still accept
    push = (state_q == RUN) && !bus.halt && !bus.redirect_valid &&
           ((count_q < DEPTH_C) || pop);

    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (bus.halt && !bus.redirect_valid) state_d = HALTED;
      HALTED:  if (!bus.halt) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (bus.redirect_valid) begin
      // flush: the same-cycle pop still counts, everything behind it dies
      count_d  = '0;
      wr_ptr_d = rd_ptr_d;
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        q_mem_d[wr_ptr_q].instr = bus.imem_data;
        q_mem_d[wr_ptr_q].pc    = pc_q;
        wr_ptr_d                = wr_ptr_q + PW'(1);
        pc_d                    = pc_q + 32'd4;
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      q_mem_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      q_mem_q  <= q_mem_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = (count_q != '0);
  assign bus.dec_instr = q_mem_q[rd_ptr_q].instr;
  assign bus.dec_pc    = q_mem_q[rd_ptr_q].pc;
  assign bus.busy      = (state_q == RUN) || (count_q != '0);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (push) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_count_q <= '0;
    else      fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed bench for inst_fetch_ctrl (QDEPTH=2,
// RESET_PC=0). Memory returns three fixed words at 0x0/0x4/0x8 and
// {16'hC0DE, addr[15:0]} everywhere else.
module tb_inst_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2001_0007;
      32'h4:   return 32'h2002_0003;
      32'h8:   return 32'h0022_2024;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb bus.imem_data = mem_word(bus.imem_addr);

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // hold reset two edges, release just after an edge; next step() is edge 1
  task automatic apply_reset(input logic rdy);
    bus.dec_ready      = rdy;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    bus.dec_ready      = 1'b1;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // reset state
    #3;
    chk("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("rst_busy",      {31'b0, bus.busy},      32'd0);
    chk("rst_dec_instr", bus.dec_instr,          32'h0);
    chk("rst_dec_pc",    bus.dec_pc,             32'h0);
    chk("rst_imem_addr", bus.imem_addr,          32'h0);
    step(1);
    rst = 1'b1;

    // reset release stream
    step(1);
    chk("rel_e1_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("rel_e1_busy",  {31'b0, bus.busy},      32'd1);
    step(1);
    chk("rel_e2_valid", {31'b0, bus.dec_valid}, 32'd1);
    chk("rel_pc0",      bus.dec_pc,             32'h0);
    chk("rel_instr0",   bus.dec_instr,          32'h2001_0007);
    step(1);
    chk("rel_pc4",      bus.dec_pc,             32'h4);
    chk("rel_instr4",   bus.dec_instr,          32'h2002_0003);
    step(1);
    chk("rel_pc8",      bus.dec_pc,             32'h8);
    chk("rel_instr8",   bus.dec_instr,          32'h0022_2024);

    // backpressure: full after two pushes, pc held at 0x8
    apply_reset(1'b0);
    step(6);
    chk("bp_imem_addr", bus.imem_addr,          32'h8);
    chk("bp_valid",     {31'b0, bus.dec_valid}, 32'd1);
    chk("bp_head",      bus.dec_pc,             32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("bp_fetch_count", fetch_count,          32'd2);
`endif
    bus.dec_ready = 1'b1;
    step(1);
    chk("bp_pc4",       bus.dec_pc,             32'h4);
    step(1);
    chk("bp_pc8",       bus.dec_pc,             32'h8);

    // redirect with simultaneous pop
    apply_reset(1'b0);
    step(3);
    bus.dec_ready = 1'b1;
    step(1);
    chk("rd_head4",     bus.dec_pc,             32'h4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_000D;
    step(1);
    chk("rd_flush",     {31'b0, bus.dec_valid}, 32'd0);
    chk("rd_imem_addr", bus.imem_addr,          32'hC);
    bus.redirect_valid = 1'b0;
    step(1);
    chk("rd_valid",     {31'b0, bus.dec_valid}, 32'd1);
    chk("rd_pcC",       bus.dec_pc,             32'hC);
    chk("rd_instrC",    bus.dec_instr,          32'hC0DE_000C);

    // halt with two entries, drain, resume at same pc
    bus.dec_ready = 1'b0;
    step(1);
    chk("h_head",       bus.dec_pc,             32'hC);
    bus.halt = 1'b1;
    step(1);
    chk("h_busy_full",  {31'b0, bus.busy},      32'd1);
    chk("h_pc_hold",    bus.imem_addr,          32'h14);
    bus.dec_ready = 1'b1;
    step(1);
    chk("h_pop1_pc",    bus.dec_pc,             32'h10);
    chk("h_busy_one",   {31'b0, bus.busy},      32'd1);
    step(1);
    chk("h_busy_empty", {31'b0, bus.busy},      32'd0);
    chk("h_valid_0",    {31'b0, bus.dec_valid}, 32'd0);
    chk("h_pc_kept",    bus.imem_addr,          32'h14);
    bus.halt = 1'b0;
    step(1);
    chk("h_run_busy",   {31'b0, bus.busy},      32'd1);
    chk("h_run_valid",  {31'b0, bus.dec_valid}, 32'd0);
    step(1);
    chk("h_resume_pc",  bus.dec_pc,             32'h14);
    chk("h_resume_vld", {31'b0, bus.dec_valid}, 32'd1);

    // wrap-around at top of address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    chk("w_imem_addr",  bus.imem_addr,          32'hFFFF_FFFC);
    chk("w_flush",      {31'b0, bus.dec_valid}, 32'd0);
    bus.redirect_valid = 1'b0;
    step(1);
    chk("w_pc_top",     bus.dec_pc,             32'hFFFF_FFFC);
    chk("w_instr_top",  bus.dec_instr,          32'hC0DE_FFFC);
    chk("w_pc_wrapped", bus.imem_addr,          32'h0);
    step(1);
    chk("w_pc_zero",    bus.dec_pc,             32'h0);
    chk("w_instr_zero", bus.dec_instr,          32'h2001_0007);

    // redirect while halted
    bus.halt = 1'b1;
    step(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0043;
    step(1);
    chk("hr_pc",        bus.imem_addr,          32'h40);
    bus.redirect_valid = 1'b0;
    step(1);
    chk("hr_pc_hold",   bus.imem_addr,          32'h40);
    chk("hr_busy",      {31'b0, bus.busy},      32'd0);
    bus.halt = 1'b0;
    step(2);
    chk("hr_resume_pc", bus.dec_pc,             32'h40);

    // reset mid-operation with full queue after 7 pushes
    apply_reset(1'b1);
    step(7);
    bus.dec_ready = 1'b0;
    step(1);
    chk("mr_head",      bus.dec_pc,             32'h14);
    chk("mr_pc",        bus.imem_addr,          32'h1C);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_fetch_count", fetch_count,          32'd7);
`endif
    rst = 1'b0;
    #2;
    chk("mr_valid_0",   {31'b0, bus.dec_valid}, 32'd0);
    chk("mr_busy_0",    {31'b0, bus.busy},      32'd0);
    chk("mr_pc_reset",  bus.imem_addr,          32'h0);
    chk("mr_dec_pc_0",  bus.dec_pc,             32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_count_clr", fetch_count,            32'd0);
`endif
    step(1);
    rst = 1'b1;
    bus.dec_ready = 1'b1;
    step(2);
    chk("mr_restart_vld", {31'b0, bus.dec_valid}, 32'd1);
    chk("mr_restart_pc",  bus.dec_pc,             32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_count_one",   fetch_count,            32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the byte address of the first fetch after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the prefetch queue depth in entries; legal values are powers of two, 2 to 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to the instruction memory, which divides it by 4 internally.
REQ-006 SHALL have port imem_data, input, 32 bits: instruction memory read data, combinational from imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch or jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 SHALL have port halt, input, 1 bit: request to stop issuing new fetches.
REQ-010 SHALL have port dec_valid, output, 1 bit: queue head valid to decode.
REQ-011 SHALL have port dec_instr, output, 32 bits: queue head instruction.
REQ-012 SHALL have port dec_pc, output, 32 bits: byte address of dec_instr.
REQ-013 SHALL have port dec_ready, input, 1 bit: decode accepts the head this cycle.
REQ-014 SHALL have port busy, output, 1 bit: high when state is RUN or the queue is non-empty.

Function
REQ-015 SHALL implement states IDLE, RUN and HALTED: IDLE goes to RUN on the first edge; RUN goes to HALTED when halt=1 and no redirect; HALTED goes to RUN when halt=0.
REQ-016 SHALL drive imem_addr = pc in every state.
REQ-017 SHALL issue a fetch in a cycle only when state=RUN, halt=0, redirect_valid=0, and (count<QDEPTH or a pop occurs in the same cycle).
REQ-018 SHALL, on a fetch, push {imem_data, pc} into the queue and update pc to pc+4 modulo 2^32, so 32'hFFFFFFFC wraps to 0.
REQ-019 SHALL treat a pop as dec_valid & dec_ready; simultaneous push and pop leave count unchanged.
REQ-020 SHALL have no bypass: dec_valid rises on the edge after the first push into an empty queue.
REQ-021 SHALL give redirect_valid priority over push: same-cycle pop still counts as consumed, the queue is flushed (count=0), no push occurs, and pc loads {redirect_pc[31:2],2'b00}.
REQ-022 SHALL apply a redirect while HALTED by loading pc and remaining HALTED.
REQ-023 SHALL let the queue drain by pops while HALTED, with no pushes.
REQ-024 SHALL hold pc and the queue unchanged when full with no pop.
REQ-025 SHALL drive dec_instr and dec_pc from the queue head; their values when dec_valid=0 are don't-care, held at last head.

Reset
REQ-026 SHALL, while rst=0, immediately force state=IDLE, pc=RESET_PC, count=0, queue pointers=0, dec_valid=0, busy=0, dec_instr=0 and dec_pc=0.
REQ-027 SHALL discard all queued instructions on assertion of rst mid-operation, with no partial push completing.
REQ-028 SHALL place the first fetch in the cycle after the first post-reset edge and assert dec_valid after the second edge.

Configuration
REQ-029 SHALL, when FETCH_PERF_CNT_EN is defined, add output fetch_count (32 bits) counting pushes: reset to 0, +1 per push, wraps at 2^32, and not cleared by redirect.
REQ-030 SHALL, when FETCH_PERF_CNT_EN is undefined, have no fetch_count port and no counter logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover a reset-release sequence: memory words 0x20010007, 0x20020003, 0x00222024; release rst, dec_ready=1 -> dec_valid high after 2nd edge; three consecutive accepts return those words with dec_pc 0x0, 0x4, 0x8.
REQ-032 SHALL cover backpressure: dec_ready=0 for 5 cycles -> exactly QDEPTH=2 pushes, pc=0x8 held; dec_ready=1 -> dec_pc stream 0x0, 0x4, 0x8 with no gaps or duplicates.
REQ-033 SHALL cover redirect with pop: queue holding pc 0x4 and 0x8, redirect_pc=0x0000000D with dec_ready=1 -> 0x4 consumed, 0x8 dropped, next dec_pc=0xC one cycle later.
REQ-034 SHALL cover halt and resume: assert halt with 2 entries queued -> busy stays high until both popped, then 0; pc unchanged; deassert halt -> fetch resumes at the same pc.
REQ-035 SHALL cover wrap-around: redirect to 0xFFFFFFFC -> dec_pc sequence 0xFFFFFFFC, 0x00000000.
REQ-036 SHALL cover reset mid-operation with FETCH_PERF_CNT_EN defined: pull rst low after 7 pushes with queue full -> dec_valid=0 and fetch_count=0 asynchronously; after release, the fetch restarts at RESET_PC.
